// File: rtl/mips_program_loader.sv
// mips_program_loader: encodes symbolic MIPS instructions from a valid/ready stream and writes them to
// instruction memory from word 0 upward, holding the CPU in reset until the load finishes cleanly.
//   clk, reset (async, active-low)     start: begin a load (seen only in IDLE/DONE/ERROR)
//   in_valid/in_ready + in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last: instruction
//   mem_we/mem_addr/mem_wdata: one-cycle memory write    word_count: words written this load
//   cpu_hold, done, error: load status
module mips_program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} stateT;
    stateT state;
    logic lastFlag;
    logic legal;
    logic [5:0] funct, opcode;
    logic isR, isJ, isShift, isJr, isLui;
    logic [31:0] encWord;
    always_comb begin
        funct = 6'h00;
        opcode = 6'h00;
        legal = 1'b1;
        case (in_kind)
            5'd0:  funct = 6'h20;
            5'd1:  funct = 6'h22;
            5'd2:  funct = 6'h24;
            5'd3:  funct = 6'h25;
            5'd4:  funct = 6'h27;
            5'd5:  funct = 6'h00;
            5'd6:  funct = 6'h02;
            5'd7:  funct = 6'h08;
            5'd8:  opcode = 6'h08;
            5'd9:  opcode = 6'h0d;
            5'd10: opcode = 6'h0f;
            5'd11: opcode = 6'h23;
            5'd12: opcode = 6'h2b;
            5'd13: opcode = 6'h04;
            5'd14: opcode = 6'h05;
            5'd15: opcode = 6'h02;
            5'd16: opcode = 6'h03;
            default: legal = 1'b0;
        endcase
    end
    assign isR     = in_kind < 5'd8;
    assign isJ     = in_kind == 5'd15 || in_kind == 5'd16;
    assign isShift = in_kind == 5'd5 || in_kind == 5'd6;
    assign isJr    = in_kind == 5'd7;
    assign isLui   = in_kind == 5'd10;
    // Unused fields are forced to zero so the word matches what an assembler would emit.
    assign encWord = isR ? (isJr    ? {6'h00, in_rs, 15'h0000, funct} :
                            isShift ? {6'h00, 5'h00, in_rt, in_rd, in_shamt, funct} :
                                      {6'h00, in_rs, in_rt, in_rd, 5'h00, funct}) :
                     isJ ? {opcode, in_target} :
                           {opcode, isLui ? 5'h00 : in_rs, in_rt, in_imm};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lastFlag   <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (legal) begin
                            // Outputs for the write cycle are loaded here so they are registered.
                            state      <= WRITE;
                            lastFlag   <= in_last;
                            mem_we     <= 1'b1;
                            mem_wdata  <= encWord;
                            word_count <= word_count + (ADDR_WIDTH+1)'(1);
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (lastFlag) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (mem_addr == {ADDR_WIDTH{1'b1}}) begin
                        // Memory is full and more words are coming: never wrap onto word 0.
                        state <= ERROR;
                        error <= 1'b1;
                    end else begin
                        state    <= ACCEPT;
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state      <= ACCEPT;
                        in_ready   <= 1'b1;
                        mem_addr   <= '0;
                        word_count <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_program_loader.sv
// tb_mips_program_loader: scoreboard bench for mips_program_loader (8-bit and 2-bit address instances).
module tb_mips_program_loader;
    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wrT;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic startA = 1'b0, startB = 1'b0;
    logic validA = 1'b0, validB = 1'b0;
    logic [4:0] kind = '0, rs = '0, rt = '0, rd = '0, sh = '0;
    logic [15:0] imm = '0;
    logic [25:0] tgt = '0;
    logic last = 1'b0;
    logic readyA, weA, holdA, doneA, errA;
    logic [7:0] addrA;
    logic [31:0] dataA, dataB;
    logic [8:0] countA;
    logic readyB, weB, holdB, doneB, errB;
    logic [1:0] addrB;
    logic [2:0] countB;
    wrT qA[$], qB[$];
    int nextA = 0, nextB = 0;
    int checks = 0, errors = 0;
    mips_program_loader #(.ADDR_WIDTH(8)) dutA (
        .clk(clk), .reset(reset), .start(startA), .in_valid(validA), .in_ready(readyA),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_imm(imm),
        .in_target(tgt), .in_last(last), .mem_we(weA), .mem_addr(addrA), .mem_wdata(dataA),
        .word_count(countA), .cpu_hold(holdA), .done(doneA), .error(errA)
    );
    mips_program_loader #(.ADDR_WIDTH(2)) dutB (
        .clk(clk), .reset(reset), .start(startB), .in_valid(validB), .in_ready(readyB),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_imm(imm),
        .in_target(tgt), .in_last(last), .mem_we(weB), .mem_addr(addrB), .mem_wdata(dataB),
        .word_count(countB), .cpu_hold(holdB), .done(doneB), .error(errB)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
    always @(negedge clk) begin
        if (weA) begin
            checks++;
            if (qA.size() == 0) begin
                errors++;
                $display("FAIL writeA: unexpected write addr=%0d data=%h, expected no write", addrA, dataA);
            end else begin
                wrT e;
                e = qA.pop_front();
                if ({addrA, dataA} !== {e.a, e.d}) begin
                    errors++;
                    $display("FAIL writeA: got addr=%0d data=%h, expected addr=%0d data=%h", addrA, dataA, e.a, e.d);
                end
            end
        end
        if (weB) begin
            checks++;
            if (qB.size() == 0) begin
                errors++;
                $display("FAIL writeB: unexpected write addr=%0d data=%h, expected no write", addrB, dataB);
            end else begin
                wrT e;
                e = qB.pop_front();
                if ({6'b0, addrB, dataB} !== {e.a, e.d}) begin
                    errors++;
                    $display("FAIL writeB: got addr=%0d data=%h, expected addr=%0d data=%h", addrB, dataB, e.a, e.d);
                end
            end
        end
    end
    function automatic logic [31:0] model(input logic [4:0] k, input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] a, input logic [15:0] i,
                                          input logic [25:0] j);
        case (k)
            5'd0:  return {6'd0, s, t, d, 5'd0, 6'h20};
            5'd1:  return {6'd0, s, t, d, 5'd0, 6'h22};
            5'd2:  return {6'd0, s, t, d, 5'd0, 6'h24};
            5'd3:  return {6'd0, s, t, d, 5'd0, 6'h25};
            5'd4:  return {6'd0, s, t, d, 5'd0, 6'h27};
            5'd5:  return {6'd0, 5'd0, t, d, a, 6'h00};
            5'd6:  return {6'd0, 5'd0, t, d, a, 6'h02};
            5'd7:  return {6'd0, s, 5'd0, 5'd0, 5'd0, 6'h08};
            5'd8:  return {6'h08, s, t, i};
            5'd9:  return {6'h0d, s, t, i};
            5'd10: return {6'h0f, 5'd0, t, i};
            5'd11: return {6'h23, s, t, i};
            5'd12: return {6'h2b, s, t, i};
            5'd13: return {6'h04, s, t, i};
            5'd14: return {6'h05, s, t, i};
            5'd15: return {6'h02, j};
            default: return {6'h03, j};
        endcase
    endfunction
    task automatic startLoad(input bit b);
        @(negedge clk);
        if (b) startB = 1'b1; else startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        if (b) nextB = 0; else nextA = 0;
    endtask
    task automatic send(input bit b, input logic [4:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] a, input logic [15:0] i, input logic [25:0] j,
                        input logic l, input bit expWrite, input logic [31:0] expWord, output bit accepted);
        int n = 0;
        wrT e;
        while (!(b ? readyB : readyA) && n < 20) begin
            @(negedge clk);
            n++;
        end
        accepted = b ? readyB : readyA;
        if (!accepted) return;
        kind = k; rs = s; rt = t; rd = d; sh = a; imm = i; tgt = j; last = l;
        if (b) validB = 1'b1; else validA = 1'b1;
        if (expWrite) begin
            e.a = 8'(b ? nextB : nextA);
            e.d = expWord;
            if (b) begin qB.push_back(e); nextB++; end
            else begin qA.push_back(e); nextA++; end
        end
        @(negedge clk);
        validA = 1'b0;
        validB = 1'b0;
        last = 1'b0;
    endtask
    task automatic waitEnd(input bit b);
        int n = 0;
        while (!(b ? (doneB | errB) : (doneA | errA)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(b ? (doneB | errB) : (doneA | errA))) begin
            errors++;
            $display("FAIL waitEnd: no done/error after 20 cycles, expected one");
        end
    endtask
    task automatic checkStatus(input string name, input logic [8:0] expCount, input logic expDone,
                               input logic expErr, input logic expHold);
        checks++;
        if ({countA, doneA, errA, holdA} !== {expCount, expDone, expErr, expHold}) begin
            errors++;
            $display("FAIL %s: got count=%0d done=%b error=%b hold=%b, expected count=%0d done=%b error=%b hold=%b",
                     name, countA, doneA, errA, holdA, expCount, expDone, expErr, expHold);
        end
    endtask
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({readyA, weA, addrA, dataA, countA, holdA, doneA, errA} !== {1'b0, 1'b0, 8'd0, 32'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got ready=%b we=%b addr=%0d data=%h count=%0d hold=%b done=%b err=%b, expected 0 0 0 0 0 1 0 0",
                     readyA, weA, addrA, dataA, countA, holdA, doneA, errA);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_single();
        bit ok;
        startLoad(0);
        send(0, 5'd0, 5'd9, 5'd10, 5'd8, 5'd0, 16'd0, 26'd0, 1'b1, 1'b1, 32'h012A4020, ok);
        waitEnd(0);
        checkStatus("single", 9'd1, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic test_program();
        bit ok;
        startLoad(0);
        send(0, 5'd8, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0, 1'b1, 32'h20080005, ok);
        send(0, 5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0, 1'b1, 32'h8FA80004, ok);
        send(0, 5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100004, 1'b1, 1'b1, 32'h08100004, ok);
        waitEnd(0);
        checkStatus("program", 9'd3, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic test_shift();
        bit ok;
        startLoad(0);
        send(0, 5'd5, 5'd7, 5'd9, 5'd8, 5'd2, 16'hFFFF, 26'd0, 1'b1, 1'b1, 32'h00094080, ok);
        waitEnd(0);
        checkStatus("shift", 9'd1, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic test_illegal();
        bit ok;
        startLoad(0);
        send(0, 5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1, 1'b0, 32'd0, ok);
        waitEnd(0);
        checkStatus("illegal", 9'd0, 1'b0, 1'b1, 1'b1);
        startLoad(0);
        checkStatus("restart", 9'd0, 1'b0, 1'b0, 1'b1);
        send(0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b1, 1'b1, 32'h00221820, ok);
        waitEnd(0);
        checkStatus("recover", 9'd1, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic test_random();
        bit ok;
        logic [4:0] k, s, t, d, a;
        logic [15:0] i;
        logic [25:0] j;
        startLoad(0);
        for (int n = 0; n < 16; n++) begin
            k = 5'($urandom_range(0, 16));
            s = 5'($urandom); t = 5'($urandom); d = 5'($urandom); a = 5'($urandom);
            i = 16'($urandom); j = 26'($urandom);
            send(0, k, s, t, d, a, i, j, n == 15, 1'b1, model(k, s, t, d, a, i, j), ok);
        end
        waitEnd(0);
        checkStatus("random", 9'd16, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic test_overflow();
        bit ok;
        startLoad(1);
        for (int n = 0; n < 4; n++)
            send(1, 5'd3, 5'(n), 5'd4, 5'd5, 5'd0, 16'd0, 26'd0, 1'b0, 1'b1,
                 model(5'd3, 5'(n), 5'd4, 5'd5, 5'd0, 16'd0, 26'd0), ok);
        send(1, 5'd3, 5'd1, 5'd4, 5'd5, 5'd0, 16'd0, 26'd0, 1'b0, 1'b0, 32'd0, ok);
        checks++;
        if ({ok, errB, holdB, doneB, countB} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL overflow: got accepted=%b error=%b hold=%b done=%b count=%0d, expected 0 1 1 0 4",
                     ok, errB, holdB, doneB, countB);
        end
    endtask
    task automatic test_back_to_back();
        wrT e;
        startLoad(0);
        kind = 5'd1; rs = 5'd2; rt = 5'd3; rd = 5'd4; sh = 5'd0; last = 1'b0;
        validA = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (readyA !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b, expected %b", k, readyA, (k % 2 == 0));
            end
            if (k % 2 == 0 && k <= 4) begin
                e.a = 8'(k / 2);
                e.d = 32'h00432022;
                qA.push_back(e);
            end
            if (k < 5) @(negedge clk);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({readyA, weA, addrA, dataA, countA, holdA, doneA, errA} !== {1'b0, 1'b0, 8'd0, 32'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset: got ready=%b we=%b addr=%0d data=%h count=%0d hold=%b done=%b err=%b, expected 0 0 0 0 0 1 0 0",
                     readyA, weA, addrA, dataA, countA, holdA, doneA, errA);
        end
        validA = 1'b0;
        reset = 1'b1;
        @(negedge clk);
    endtask
    initial begin
        test_reset();
        test_single();
        test_program();
        test_shift();
        test_illegal();
        test_random();
        test_overflow();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (qA.size() + qB.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected writes never seen, expected 0", qA.size() + qB.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
